// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM port between NUM_REQ requesters.
// Two-stage pipeline: grant/issue register, then read-data capture with one-hot rvalid.
module dpram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            ram_cs,
  output logic                            ram_we,
  output logic                            ram_oe,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  inout  wire  [DATA_WIDTH-1:0]           ram_data
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: req is a level sampled at every edge; gnt pulses for one cycle when
  // that request is accepted, and a req still high afterwards counts as a new request.

  logic [LW-1:0]         last_q, last_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LW-1:0]         rd_idx_q, rd_idx_d;

  logic                  found;
  logic [LW-1:0]         win;
  int                    idx;
  int                    win_i;

  always_comb begin
    found    = 1'b0;
    win      = last_q;
    idx      = 0;
    // Search starts just after the previous winner so it has lowest priority now.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
    win_i    = int'(win);

    last_d   = last_q;
    gnt_d    = '0;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    oe_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_idx_d = rd_idx_q;
    if (found) begin
      gnt_d[win_i] = 1'b1;
      last_d       = win;
      cs_d         = 1'b1;
      we_d         = req_we[win_i];
      oe_d         = !req_we[win_i];
      addr_d       = req_addr[win_i*ADDR_WIDTH +: ADDR_WIDTH];
      if (req_we[win_i]) wdata_d = req_wdata[win_i*DATA_WIDTH +: DATA_WIDTH];
      else               rd_idx_d = win;
    end

    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (cs_q && oe_q) begin
      rvalid_d[rd_idx_q] = 1'b1;
      rdata_d            = ram_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= LW'(NUM_REQ - 1);
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_idx_q <= '0;
    end else begin
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Bus is released whenever no write is in progress, including during reset.
  assign ram_data = (cs_q && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign ram_cs   = cs_q;
  assign ram_we   = we_q;
  assign ram_oe   = oe_q;
  assign ram_addr = addr_q;

endmodule
